beta_decode: RTL

Registered instruction-decode stage of the Beta processor. It sits directly upstream of `regfile`. It accepts fetched instructions over a valid/ready handshake, extracts the register addresses, and drives `regfile` and the downstream datapath with decoded control: RegWrite, RegDst, ALU function, operand/writeback selects, and memory/branch controls. A 2-entry skid buffer decouples `in_ready` from `out_ready`. The stage also sustains one instruction per cycle, supports pipeline flush, and counts illegal opcodes.

---
 rtl/beta_pkg.sv | 61 ++++++
 rtl/beta_decode_if.sv | 43 ++++
 rtl/beta_skid_buf.sv | 86 ++++++++
 rtl/beta_decode.sv | 112 +++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beta_pkg : opcodes, decoded-bundle types and legality check for the  |
// |            Beta decode stage.                     Revision: 1.0      |
// +----------------------------------------------------------------------+
package beta_pkg;

  localparam logic [5:0] OP_LD   = 6'h18;
  localparam logic [5:0] OP_ST   = 6'h19;
  localparam logic [5:0] OP_JMP  = 6'h1B;
  localparam logic [5:0] OP_BEQ  = 6'h1C;
  localparam logic [5:0] OP_BNE  = 6'h1D;
  localparam logic [5:0] OP_LDR  = 6'h1F;
  localparam logic [5:0] OP_ALU  = 6'h20;
  localparam logic [5:0] OP_ALUC = 6'h30;

  localparam logic [4:0] ILL_RC  = 5'd30;

  typedef enum logic [1:0] {
    WD_PC  = 2'd0,
    WD_ALU = 2'd1,
    WD_MEM = 2'd2
  } wdsel_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JMP  = 2'd1,
    BR_BEQ  = 2'd2,
    BR_BNE  = 2'd3
  } branch_t;

  typedef struct packed {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rc;
    logic        reg_write;
    logic        reg_dst;
    logic [3:0]  alufn;
    logic        bsel;
    wdsel_t      wdsel;
    logic        mem_rd;
    logic        mem_wr;
    branch_t     branch;
    logic [31:0] lit;
    logic [31:0] pc;
    logic        illop;
  } dec_bundle_t;

  // The 0x20-0x3F block holds ALU and ALUC ops; function codes 7, B and F are unused there.
  function automatic logic is_legal(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR: legal = 1'b1;
      default: legal = op[5] && (op[3:0] != 4'h7) && (op[3:0] != 4'hB) && (op[3:0] != 4'hF);
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beta_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beta_decode_if : instruction-in / decoded-bundle-out handshake bus.  |
// |                                                   Revision: 1.0      |
// +----------------------------------------------------------------------+
interface beta_decode_if;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  rc;
  logic        RegWrite;
  logic        RegDst;
  logic [3:0]  alufn;
  logic        bsel;
  logic [1:0]  wdsel;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  branch;
  logic [31:0] lit;
  logic [31:0] pc_out;
  logic        illop;

  modport master (
    output flush, in_valid, instr, pc_in, out_ready,
    input  in_ready, out_valid, ra, rb, rc, RegWrite, RegDst, alufn, bsel,
           wdsel, mem_rd, mem_wr, branch, lit, pc_out, illop
  );

  modport slave (
    input  flush, in_valid, instr, pc_in, out_ready,
    output in_ready, out_valid, ra, rb, rc, RegWrite, RegDst, alufn, bsel,
           wdsel, mem_rd, mem_wr, branch, lit, pc_out, illop
  );

endinterface
`default_nettype wire

// File: rtl/beta_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beta_skid_buf : two-entry (main + skid) buffer with registered ready. |
// |                                                   Revision: 1.0      |
// +----------------------------------------------------------------------+
module beta_skid_buf #(
  parameter type T = logic [31:0]
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic flush,
  input  wire logic in_valid,
  output logic      in_ready,
  input  wire T     in_data,
  output logic      out_valid,
  input  wire logic out_ready,
  output T          out_data
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_full_q, main_full_d;
  logic skid_full_q, skid_full_d;
  logic in_ready_q, in_ready_d;
  logic accept;
  logic deliver;

  assign accept  = in_valid && in_ready_q;
  assign deliver = main_full_q && out_ready;

  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    main_full_d = main_full_q;
    skid_full_d = skid_full_q;

    if (deliver) begin
      if (skid_full_q) begin
        main_d      = skid_q;
        skid_full_d = 1'b0;
      end else begin
        main_full_d = 1'b0;
      end
    end

    // Accept lands in whichever slot is free after this edge's delivery.
    if (accept) begin
      if (!main_full_d) begin
        main_d      = in_data;
        main_full_d = 1'b1;
      end else begin
        skid_d      = in_data;
        skid_full_d = 1'b1;
      end
    end

    if (flush) begin
      main_full_d = 1'b0;
      skid_full_d = 1'b0;
    end

    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_full_q <= main_full_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_full_q;
  assign out_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/beta_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beta_decode : registered Beta instruction decode with skid buffer     |
// |               and saturating illegal-opcode counter.  Revision: 1.0  |
// +----------------------------------------------------------------------+
module beta_decode
  import beta_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  beta_decode_if.slave bus,
  output logic [CNT_W-1:0] ill_count
);

  function automatic dec_bundle_t decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_bundle_t b;
    logic [5:0]  op;
    op          = ins[31:26];
    b           = '0;
    b.ra        = ins[20:16];
    b.rb        = ins[15:11];
    b.rc        = ins[25:21];
    b.lit       = {{16{ins[15]}}, ins[15:0]};
    b.pc        = pc;
    b.wdsel     = WD_PC;
    b.branch    = BR_NONE;
    b.reg_write = 1'b1;
    if (!is_legal(op)) begin
      // Illegal ops trap: write PC+4 into XP (R30).
      b.illop = 1'b1;
      b.rc    = ILL_RC;
    end else begin
      case (op)
        OP_LD: begin
          b.bsel   = 1'b1;
          b.wdsel  = WD_MEM;
          b.mem_rd = 1'b1;
        end
        OP_ST: begin
          b.reg_write = 1'b0;
          b.reg_dst   = 1'b1;
          b.bsel      = 1'b1;
          b.mem_wr    = 1'b1;
        end
        OP_JMP: b.branch = BR_JMP;
        OP_BEQ: b.branch = BR_BEQ;
        OP_BNE: b.branch = BR_BNE;
        OP_LDR: begin
          b.wdsel  = WD_MEM;
          b.mem_rd = 1'b1;
        end
        default: begin
          b.alufn = op[3:0];
          b.bsel  = op[4];
          b.wdsel = WD_ALU;
        end
      endcase
    end
    return b;
  endfunction

  dec_bundle_t dec;
  dec_bundle_t head;
  logic [CNT_W-1:0] ill_count_q, ill_count_d;

  assign dec = decode(bus.instr, bus.pc_in);

  beta_skid_buf #(
    .T (dec_bundle_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  always_comb begin
    ill_count_d = ill_count_q;
    if (bus.out_valid && bus.out_ready && head.illop && (ill_count_q != '1))
      ill_count_d = ill_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_count_q <= '0;
    else        ill_count_q <= ill_count_d;
  end

  assign ill_count    = ill_count_q;
  assign bus.ra       = head.ra;
  assign bus.rb       = head.rb;
  assign bus.rc       = head.rc;
  assign bus.RegWrite = head.reg_write;
  assign bus.RegDst   = head.reg_dst;
  assign bus.alufn    = head.alufn;
  assign bus.bsel     = head.bsel;
  assign bus.wdsel    = head.wdsel;
  assign bus.mem_rd   = head.mem_rd;
  assign bus.mem_wr   = head.mem_wr;
  assign bus.branch   = head.branch;
  assign bus.lit      = head.lit;
  assign bus.pc_out   = head.pc;
  assign bus.illop    = head.illop;

endmodule
`default_nettype wire
